led_buffer_controller: RTL and testbench

LED_BUFFER_CONTROLLER -- requirements
Module: led_buffer_controller

---
 rtl/led_buffer_controller.sv | 122 ++++++++++++
 tb/tb_led_buffer_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_buffer_controller.sv
// Double-buffered LED panel frame store: scanner reads the front buffer while a
// writer fills or clears the back buffer; swaps are committed at end of frame.
module led_buffer_controller (
   input  logic        clkIn,
   input  logic        rst,
   input  logic [10:0] pixelAddress0,
   input  logic [10:0] pixelAddress1,
   output logic [7:0]  pixel0,
   output logic [7:0]  pixel1,
   input  logic        done,
   input  logic        wrReq,
   input  logic        wrHalf,
   input  logic [10:0] wrAddr,
   input  logic [7:0]  wrData,
   output logic        wrAck,
   input  logic        swapReq,
   input  logic        clrReq,
   output logic        busy,
   output logic        swapAck,
   output logic        frontSel,
   output logic [15:0] frameCount
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLEAR   = 2'd1,
      PENDING = 2'd2
   } state_t;

   state_t      state;
   logic        rstSync;
   logic        pendSwap;
   logic [10:0] clearAddr;

   // Each half stores both buffers; the top address bit selects the buffer.
   logic [7:0]  upperMem [0:4095];
   logic [7:0]  lowerMem [0:4095];

   logic        wrAccept;
   logic        clearing;
   logic        upperWe;
   logic        lowerWe;
   logic [11:0] backAddr;
   logic [7:0]  backData;

   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge clkIn or negedge rst) begin
      if (!rst) rstSync <= 1'b0;
      else      rstSync <= 1'b1;
   end

   always_comb begin
      wrAccept = rstSync && (state == IDLE) && wrReq && !clrReq;
      clearing = rstSync && (state == CLEAR);
      upperWe  = clearing || (wrAccept && !wrHalf);
      lowerWe  = clearing || (wrAccept && wrHalf);
      backAddr = {~frontSel, (clearing ? clearAddr : wrAddr)};
      backData = clearing ? '0 : wrData;
      busy     = (state != IDLE);
   end

   always_ff @(posedge clkIn) begin
      if (upperWe) upperMem[backAddr] <= backData;
      if (lowerWe) lowerMem[backAddr] <= backData;
   end

   always_ff @(posedge clkIn or negedge rstSync) begin
      if (!rstSync) begin
         pixel0 <= '0;
         pixel1 <= '0;
      end else begin
         pixel0 <= upperMem[{frontSel, pixelAddress0}];
         pixel1 <= lowerMem[{frontSel, pixelAddress1}];
      end
   end

   always_ff @(posedge clkIn or negedge rstSync) begin
      if (!rstSync) begin
         state      <= IDLE;
         frontSel   <= 1'b0;
         frameCount <= '0;
         pendSwap   <= 1'b0;
         clearAddr  <= '0;
         wrAck      <= 1'b0;
         swapAck    <= 1'b0;
      end else begin
         wrAck   <= 1'b0;
         swapAck <= 1'b0;
         if (done) frameCount <= frameCount + 16'd1;

         unique case (state)
            IDLE: begin
               if (clrReq) begin
                  state     <= CLEAR;
                  clearAddr <= '0;
                  pendSwap  <= swapReq;
               end else begin
                  wrAck <= wrReq;
                  if (swapReq) state <= PENDING;
               end
            end
            CLEAR: begin
               clearAddr <= clearAddr + 11'd1;
               if (swapReq) pendSwap <= 1'b1;
               if (clearAddr == '1) begin
                  state    <= (pendSwap || swapReq) ? PENDING : IDLE;
                  pendSwap <= 1'b0;
               end
            end
            PENDING: begin
               if (done) begin
                  frontSel <= ~frontSel;
                  swapAck  <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_buffer_controller.sv
// Directed bench for led_buffer_controller with a queue of expected registered outputs.
module tb_led_buffer_controller;

   logic        clkIn = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] pixelAddress0 = '0;
   logic [10:0] pixelAddress1 = '0;
   logic [7:0]  pixel0;
   logic [7:0]  pixel1;
   logic        done = 1'b0;
   logic        wrReq = 1'b0;
   logic        wrHalf = 1'b0;
   logic [10:0] wrAddr = '0;
   logic [7:0]  wrData = '0;
   logic        wrAck;
   logic        swapReq = 1'b0;
   logic        clrReq = 1'b0;
   logic        busy;
   logic        swapAck;
   logic        frontSel;
   logic [15:0] frameCount;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int          kind;
      logic [15:0] exp;
      string       tag;
   } item_t;

   item_t sb[$];
   logic [7:0] mdl [0:1][0:2047];

   led_buffer_controller dut (
      .clkIn(clkIn), .rst(rst),
      .pixelAddress0(pixelAddress0), .pixelAddress1(pixelAddress1),
      .pixel0(pixel0), .pixel1(pixel1), .done(done),
      .wrReq(wrReq), .wrHalf(wrHalf), .wrAddr(wrAddr), .wrData(wrData),
      .wrAck(wrAck), .swapReq(swapReq), .clrReq(clrReq), .busy(busy),
      .swapAck(swapAck), .frontSel(frontSel), .frameCount(frameCount)
   );

   always #5 clkIn = ~clkIn;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] obs_of(input int kind);
      case (kind)
         0:       return {8'h00, pixel0};
         1:       return {8'h00, pixel1};
         2:       return {15'h0, wrAck};
         default: return {15'h0, swapAck};
      endcase
   endfunction

   task automatic push(input int kind, input logic [15:0] exp, input string tag);
      item_t it;
      it.kind = kind;
      it.exp  = exp;
      it.tag  = tag;
      sb.push_back(it);
   endtask

   // Every queued expectation refers to the edge this task waits for.
   task automatic tick();
      item_t it;
      @(posedge clkIn);
      #1;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         chk(it.tag, obs_of(it.kind), it.exp);
      end
   endtask

   initial begin
      int n;
      logic [10:0] a;

      repeat (2) @(posedge clkIn);
      #1;
      chk("rst_pixel0", {8'h00, pixel0}, 16'h0);
      chk("rst_pixel1", {8'h00, pixel1}, 16'h0);
      chk("rst_wrAck", {15'h0, wrAck}, 16'h0);
      chk("rst_swapAck", {15'h0, swapAck}, 16'h0);
      chk("rst_frontSel", {15'h0, frontSel}, 16'h0);
      chk("rst_frameCount", frameCount, 16'h0);
      chk("rst_busy", {15'h0, busy}, 16'h0);
      rst = 1'b1;
      tick();
      tick();

      // single write into back buffer 1, then swap on done
      wrReq = 1'b1; wrHalf = 1'b0; wrAddr = 11'd5; wrData = 8'h2A;
      push(2, 16'h1, "ack_single");
      tick();
      wrReq = 1'b0; swapReq = 1'b1;
      tick();
      chk("ack_drop", {15'h0, wrAck}, 16'h0);
      chk("pend_busy", {15'h0, busy}, 16'h1);
      swapReq = 1'b0; done = 1'b1;
      tick();
      done = 1'b0;
      chk("swap1_front", {15'h0, frontSel}, 16'h1);
      chk("swap1_ack", {15'h0, swapAck}, 16'h1);
      chk("swap1_busy", {15'h0, busy}, 16'h0);
      chk("swap1_frames", frameCount, 16'd1);
      pixelAddress0 = 11'd5;
      push(0, 16'h2A, "rd_after_swap");
      tick();
      chk("swap1_ack_pulse", {15'h0, swapAck}, 16'h0);

      // burst of 10 writes into back buffer 0 while front buffer 1 is read
      for (int i = 0; i < 10; i++) begin
         a = (i == 4) ? 11'd5 : 11'(i);
         wrReq = 1'b1; wrHalf = i[0]; wrAddr = a; wrData = 8'h80 + 8'(i);
         mdl[i % 2][a] = 8'h80 + 8'(i);
         push(2, 16'h1, "ack_burst");
         pixelAddress0 = 11'd5;
         push(0, 16'h2A, "front_guard");
         tick();
      end
      wrReq = 1'b0;
      tick();
      chk("burst_ack_end", {15'h0, wrAck}, 16'h0);

      // swapReq together with done: no swap until the next done
      swapReq = 1'b1; done = 1'b1;
      tick();
      swapReq = 1'b0; done = 1'b0;
      chk("coinc_front", {15'h0, frontSel}, 16'h1);
      chk("coinc_swapAck", {15'h0, swapAck}, 16'h0);
      chk("coinc_busy", {15'h0, busy}, 16'h1);
      chk("coinc_frames", frameCount, 16'd2);
      tick();
      tick();
      chk("coinc_hold", {15'h0, frontSel}, 16'h1);
      done = 1'b1; pixelAddress0 = 11'd5;
      push(0, 16'h2A, "inflight_old_buf");
      tick();
      done = 1'b0;
      chk("swap2_front", {15'h0, frontSel}, 16'h0);
      chk("swap2_ack", {15'h0, swapAck}, 16'h1);
      chk("swap2_frames", frameCount, 16'd3);
      for (int i = 0; i < 10; i++) begin
         a = (i == 4) ? 11'd5 : 11'(i);
         pixelAddress0 = a; pixelAddress1 = a;
         if (i % 2 == 0) push(0, {8'h00, mdl[0][a]}, "burst_rd_upper");
         else            push(1, {8'h00, mdl[1][a]}, "burst_rd_lower");
         tick();
      end

      // clear back buffer 1 with a swap latched mid-clear
      clrReq = 1'b1;
      tick();
      clrReq = 1'b0;
      chk("clr_busy", {15'h0, busy}, 16'h1);
      for (int c = 0; c < 2048; c++) begin
         wrReq = (c == 50); wrAddr = 11'd3; wrData = 8'h55; wrHalf = 1'b0;
         swapReq = (c == 100);
         tick();
         if (c == 50) chk("clr_noack", {15'h0, wrAck}, 16'h0);
      end
      chk("clr_to_pending", {15'h0, busy}, 16'h1);
      wrReq = 1'b1; wrAddr = 11'd7; wrData = 8'h77; clrReq = 1'b1;
      tick();
      wrReq = 1'b0; clrReq = 1'b0;
      chk("pend_noack", {15'h0, wrAck}, 16'h0);
      tick();
      chk("pend_hold", {15'h0, busy}, 16'h1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("swap3_front", {15'h0, frontSel}, 16'h1);
      chk("swap3_ack", {15'h0, swapAck}, 16'h1);
      for (int i = 0; i < 2048; i++) begin
         pixelAddress0 = 11'(i); pixelAddress1 = 11'(i);
         push(0, 16'h0, "cleared_upper");
         push(1, 16'h0, "cleared_lower");
         tick();
      end

      // clear without swap lasts exactly 2048 cycles then returns to idle
      clrReq = 1'b1;
      tick();
      clrReq = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         n++;
         tick();
      end
      chk("clr_length", 16'(n), 16'd2048);
      chk("clr_front_kept", {15'h0, frontSel}, 16'h1);

      // reset during PENDING aborts the swap
      swapReq = 1'b1;
      tick();
      swapReq = 1'b0;
      chk("pend2_busy", {15'h0, busy}, 16'h1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_front", {15'h0, frontSel}, 16'h0);
      chk("mid_rst_busy", {15'h0, busy}, 16'h0);
      chk("mid_rst_frames", frameCount, 16'h0);
      @(posedge clkIn);
      #1;
      rst = 1'b1;
      tick();
      tick();
      done = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("post_rst_swapAck", {15'h0, swapAck}, 16'h0);
         chk("post_rst_front", {15'h0, frontSel}, 16'h0);
      end
      done = 1'b0;

      // frameCount wraps after 65536 done pulses from reset
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      chk("wrap_start", frameCount, 16'h0);
      done = 1'b1;
      repeat (65535) tick();
      chk("wrap_max", frameCount, 16'hFFFF);
      tick();
      done = 1'b0;
      chk("wrap_zero", frameCount, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
